// File: rtl/pe_dispatcher_if.sv
// Signal bundle between pe_dispatcher (master) and the host/PE array (slave).
// Abort request/status exist only when PE_DISPATCH_ABORT_EN is defined.
interface pe_dispatcher_if #(
    parameter int PE_COUNT = 4,
    parameter int ROW_W    = 32
);
    logic                      go;
    logic [ROW_W-1:0]          m;
    logic [2*PE_COUNT-1:0]     start_signal;
    logic [ROW_W*PE_COUNT-1:0] row_idx;
    logic [PE_COUNT-1:0]       pe_done;
    logic                      busy;
    logic                      done;
    logic [ROW_W-1:0]          rows_done;
`ifdef PE_DISPATCH_ABORT_EN
    logic                      abort;
    logic                      aborted;

    modport master (
        input  go, m, pe_done, abort,
        output start_signal, row_idx, busy, done, rows_done, aborted
    );
    modport slave (
        output go, m, pe_done, abort,
        input  start_signal, row_idx, busy, done, rows_done, aborted
    );
`else
    modport master (
        input  go, m, pe_done,
        output start_signal, row_idx, busy, done, rows_done
    );
    modport slave (
        output go, m, pe_done,
        input  start_signal, row_idx, busy, done, rows_done
    );
`endif
endinterface

// File: rtl/pe_dispatcher.sv
// Hands out result rows of a job to PE_COUNT PEs via 2-bit start codes and counts completions.
// Optional job abort (code 11, sticky aborted flag) is built when PE_DISPATCH_ABORT_EN is defined.
module pe_dispatcher #(
    parameter int PE_COUNT = 4,
    parameter int ROW_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    pe_dispatcher_if.master bus
);
    localparam int CNT_W = $clog2(PE_COUNT + 1);

    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_START = 2'b01;
    localparam logic [1:0] C_HOLD  = 2'b10;
`ifdef PE_DISPATCH_ABORT_EN
    localparam logic [1:0] C_ABORT = 2'b11;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [PE_COUNT-1:0][1:0]       r_code, w_code_nxt;
    logic [PE_COUNT-1:0][ROW_W-1:0] r_row, w_row_nxt;
    logic [ROW_W-1:0]               r_m, w_m_nxt;
    logic [ROW_W-1:0]               r_next_row, w_next_row_nxt;
    logic [ROW_W-1:0]               r_rows_done, w_rows_done_nxt;
    logic                           r_busy, w_busy_nxt;
    logic                           r_done, w_done_nxt;
    logic [ROW_W-1:0]               w_nrow;
    logic [CNT_W-1:0]               w_cnt;
    logic                           w_all_free;
`ifdef PE_DISPATCH_ABORT_EN
    logic                           r_aborted, w_aborted_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_code      <= '0;
            r_row       <= '0;
            r_m         <= '0;
            r_next_row  <= '0;
            r_rows_done <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PE_DISPATCH_ABORT_EN
            r_aborted   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_row       <= w_row_nxt;
            r_m         <= w_m_nxt;
            r_next_row  <= w_next_row_nxt;
            r_rows_done <= w_rows_done_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef PE_DISPATCH_ABORT_EN
            r_aborted   <= w_aborted_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_row_nxt       = r_row;
        w_m_nxt         = r_m;
        w_next_row_nxt  = r_next_row;
        w_rows_done_nxt = r_rows_done;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_nrow          = r_next_row;
        w_cnt           = '0;
        w_all_free      = 1'b1;
`ifdef PE_DISPATCH_ABORT_EN
        w_aborted_nxt   = r_aborted;
`endif
        for (int i = 0; i < PE_COUNT; i++) begin
            if (r_code[i] != C_IDLE) w_all_free = 1'b0;
        end

        unique case (r_state)
            S_IDLE: begin
                w_code_nxt = '0;
                if (bus.go) begin
                    // Every PE is free in IDLE, so the first batch is issued on the accepting edge.
                    w_m_nxt         = bus.m;
                    w_rows_done_nxt = '0;
                    w_busy_nxt      = 1'b1;
`ifdef PE_DISPATCH_ABORT_EN
                    w_aborted_nxt   = 1'b0;
`endif
                    w_nrow = '0;
                    for (int i = 0; i < PE_COUNT; i++) begin
                        if (w_nrow < bus.m) begin
                            w_code_nxt[i] = C_START;
                            w_row_nxt[i]  = w_nrow;
                            w_nrow        = w_nrow + ROW_W'(1);
                        end
                    end
                    w_next_row_nxt = w_nrow;
                    w_state_nxt    = (bus.m == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                // A PE freed on this edge shows 00 for a cycle before it can be picked again.
                for (int i = 0; i < PE_COUNT; i++) begin
                    unique case (r_code[i])
                        C_START: w_code_nxt[i] = C_HOLD;
                        C_HOLD: begin
                            if (bus.pe_done[i]) begin
                                w_code_nxt[i] = C_IDLE;
                                w_cnt         = w_cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            if (w_nrow < r_m) begin
                                w_code_nxt[i] = C_START;
                                w_row_nxt[i]  = w_nrow;
                                w_nrow        = w_nrow + ROW_W'(1);
                            end else begin
                                w_code_nxt[i] = C_IDLE;
                            end
                        end
                    endcase
                end
                w_next_row_nxt  = w_nrow;
                w_rows_done_nxt = r_rows_done + ROW_W'(w_cnt);
                if (w_all_free && (r_rows_done == r_m)) w_state_nxt = S_FINISH;
`ifdef PE_DISPATCH_ABORT_EN
                if (bus.abort) begin
                    for (int i = 0; i < PE_COUNT; i++) begin
                        w_code_nxt[i] = (r_code[i] != C_IDLE) ? C_ABORT : C_IDLE;
                    end
                    w_row_nxt       = r_row;
                    w_next_row_nxt  = r_next_row;
                    w_rows_done_nxt = r_rows_done;
                    w_busy_nxt      = 1'b0;
                    w_aborted_nxt   = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
`endif
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.start_signal = r_code;
    assign bus.row_idx      = r_row;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.rows_done    = r_rows_done;
`ifdef PE_DISPATCH_ABORT_EN
    assign bus.aborted      = r_aborted;
`endif

endmodule

// File: tb/tb_pe_dispatcher.sv
// Directed bench for pe_dispatcher: a job-level reference model checked every cycle
// plus hand-computed expectations for the main scenarios.
`timescale 1ns/1ps
module tb_pe_dispatcher;
    localparam int PE_COUNT = 4;
    localparam int ROW_W    = 32;

    logic clk = 1'b0;
    logic rst;
    logic [PE_COUNT-1:0] auto_done;
    logic [PE_COUNT-1:0] man_done;
    int resp_dly;
    int auto_cnt[PE_COUNT];

    int n_checks = 0;
    int n_errors = 0;

    pe_dispatcher_if #(.PE_COUNT(PE_COUNT), .ROW_W(ROW_W)) bus ();

    pe_dispatcher #(.PE_COUNT(PE_COUNT), .ROW_W(ROW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.pe_done = auto_done | man_done;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference model: which row each PE owns, how far the job has got.
    int own[PE_COUNT];
    bit fresh[PE_COUNT];
    bit flash[PE_COUNT];
    int q_m, issued, completed, phase;
    bit m_busy, m_done, m_aborted, m_post_rst, mdl_on;
    int dut_done_cnt;
    int issue_q[$];

    function automatic void mdl_reset();
        for (int i = 0; i < PE_COUNT; i++) begin
            own[i] = -1; fresh[i] = 1'b0; flash[i] = 1'b0;
        end
        q_m = 0; issued = 0; completed = 0; phase = 0;
        m_busy = 1'b0; m_done = 1'b0; m_aborted = 1'b0;
    endfunction

    function automatic void mdl_compare();
        int e;
        for (int i = 0; i < PE_COUNT; i++) begin
            e = (own[i] < 0) ? (flash[i] ? 3 : 0) : (fresh[i] ? 1 : 2);
            chk($sformatf("mdl_pe%0d_code", i), 64'(bus.start_signal[2*i +: 2]), 64'(e));
            if (e == 1)
                chk($sformatf("mdl_pe%0d_row", i), 64'(bus.row_idx[i*ROW_W +: ROW_W]), 64'(own[i]));
            if (m_post_rst)
                chk($sformatf("mdl_pe%0d_row_rst", i), 64'(bus.row_idx[i*ROW_W +: ROW_W]), 64'd0);
        end
        chk("mdl_busy", 64'(bus.busy), 64'(m_busy));
        chk("mdl_done", 64'(bus.done), 64'(m_done));
        chk("mdl_rows_done", 64'(bus.rows_done), 64'(completed));
`ifdef PE_DISPATCH_ABORT_EN
        chk("mdl_aborted", 64'(bus.aborted), 64'(m_aborted));
`endif
    endfunction

    function automatic void mdl_step();
        bit all_free;
        m_done = 1'b0;
        m_post_rst = 1'b0;
        for (int i = 0; i < PE_COUNT; i++) flash[i] = 1'b0;
        if (rst) begin
            mdl_reset();
            m_post_rst = 1'b1;
            mdl_on = 1'b1;
            return;
        end
        if (phase == 0) begin
            if (bus.go) begin
                q_m = int'(bus.m); issued = 0; completed = 0;
                m_busy = 1'b1; m_aborted = 1'b0;
                for (int i = 0; i < PE_COUNT; i++) begin
                    if (issued < q_m) begin own[i] = issued; fresh[i] = 1'b1; issued++; end
                end
                phase = (q_m == 0) ? 2 : 1;
            end
        end else if (phase == 1) begin
            all_free = 1'b1;
            for (int i = 0; i < PE_COUNT; i++) if (own[i] >= 0) all_free = 1'b0;
`ifdef PE_DISPATCH_ABORT_EN
            if (bus.abort) begin
                for (int i = 0; i < PE_COUNT; i++) begin
                    if (own[i] >= 0) flash[i] = 1'b1;
                    own[i] = -1; fresh[i] = 1'b0;
                end
                m_busy = 1'b0; m_aborted = 1'b1; phase = 0;
                return;
            end
`endif
            if (all_free && completed == q_m) begin
                phase = 2;
            end else begin
                for (int i = 0; i < PE_COUNT; i++) begin
                    if (own[i] >= 0 && fresh[i]) fresh[i] = 1'b0;
                    else if (own[i] >= 0 && bus.pe_done[i]) begin own[i] = -1; completed++; end
                    else if (own[i] < 0 && issued < q_m) begin
                        own[i] = issued; fresh[i] = 1'b1; issued++;
                    end
                end
            end
        end else begin
            m_done = 1'b1; m_busy = 1'b0; phase = 0;
        end
    endfunction

    initial begin
        mdl_on = 1'b0;
        m_post_rst = 1'b0;
        dut_done_cnt = 0;
        mdl_reset();
        forever begin
            @(negedge clk);
            if (mdl_on) mdl_compare();
            if (bus.done === 1'b1) dut_done_cnt++;
            for (int i = 0; i < PE_COUNT; i++)
                if (bus.start_signal[2*i +: 2] == 2'b01) issue_q.push_back(int'(bus.row_idx[i*ROW_W +: ROW_W]));
            mdl_step();
        end
    end

    // PE responder: pulse pe_done resp_dly cycles after a START (0 disables).
    initial begin
        auto_done = '0;
        for (int i = 0; i < PE_COUNT; i++) auto_cnt[i] = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < PE_COUNT; i++) begin
                auto_done[i] = 1'b0;
                if (rst) auto_cnt[i] = 0;
                else if (auto_cnt[i] > 0) begin
                    auto_cnt[i]--;
                    if (auto_cnt[i] == 0) auto_done[i] = 1'b1;
                end else if (resp_dly > 0 && bus.start_signal[2*i +: 2] == 2'b01)
                    auto_cnt[i] = resp_dly;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin tick(); k++; end
        chk(name, 64'(bus.done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; bus.go = 1'b0; bus.m = '0; man_done = '0; resp_dly = 0;
`ifdef PE_DISPATCH_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_start", 64'(bus.start_signal), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rows_done", 64'(bus.rows_done), 64'd0);
        tick();

        // M=3: three PEs start at once, PE3 stays idle
        resp_dly = 2;
        bus.m = 3; bus.go = 1'b1; tick(); bus.go = 1'b0;
        chk("t1_start_c1", 64'(bus.start_signal), 64'h15);
        chk("t1_row_pe1", 64'(bus.row_idx[1*ROW_W +: ROW_W]), 64'd1);
        chk("t1_row_pe2", 64'(bus.row_idx[2*ROW_W +: ROW_W]), 64'd2);
        wait_done(40, "t1_done");
        chk("t1_rows_done", 64'(bus.rows_done), 64'd3);
        chk("t1_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("t1_done_one_cycle", 64'(bus.done), 64'd0);

        // M=10 with 5-cycle PE latency
        resp_dly = 5; issue_q.delete(); dut_done_cnt = 0;
        bus.m = 10; bus.go = 1'b1; tick(); bus.go = 1'b0;
        wait_done(200, "t2_done");
        chk("t2_rows_done", 64'(bus.rows_done), 64'd10);
        repeat (5) tick();
        chk("t2_done_pulses", 64'(dut_done_cnt), 64'd1);
        chk("t2_issue_count", 64'(issue_q.size()), 64'd10);
        for (int k = 0; k < issue_q.size() && k < 10; k++)
            chk($sformatf("t2_issue_%0d", k), 64'(issue_q[k]), 64'(k));

        // M=0: done on cycle 2, nothing issued
        resp_dly = 0;
        bus.m = 0; bus.go = 1'b1; tick(); bus.go = 1'b0;
        chk("t3_busy_c1", 64'(bus.busy), 64'd1);
        chk("t3_start_c1", 64'(bus.start_signal), 64'd0);
        tick();
        chk("t3_done_c2", 64'(bus.done), 64'd1);
        chk("t3_rows_done", 64'(bus.rows_done), 64'd0);
        chk("t3_busy_c2", 64'(bus.busy), 64'd0);
        tick();

        // simultaneous dones, spurious dones, 00 gap before reassignment
        bus.m = 6; bus.go = 1'b1; tick(); bus.go = 1'b0;
        chk("t4_start_c1", 64'(bus.start_signal), 64'h55);
        tick(); tick(); man_done = 4'b0011;
        tick(); man_done = 4'b0001;
        chk("t4_start_c4", 64'(bus.start_signal), 64'hA0);
        chk("t4_rows_done_c4", 64'(bus.rows_done), 64'd2);
        tick(); man_done = 4'b0001;
        chk("t4_start_c5", 64'(bus.start_signal), 64'hA5);
        chk("t4_row_pe0", 64'(bus.row_idx[0 +: ROW_W]), 64'd4);
        chk("t4_row_pe1", 64'(bus.row_idx[ROW_W +: ROW_W]), 64'd5);
        tick(); man_done = 4'b1111;
        chk("t4_start_c6", 64'(bus.start_signal), 64'hAA);
        chk("t4_rows_done_c6", 64'(bus.rows_done), 64'd2);
        tick(); man_done = 4'b0000;
        chk("t4_rows_done_c7", 64'(bus.rows_done), 64'd6);
        wait_done(20, "t4_done");
        tick();

        // go held during a job (no relatch), then reset mid-job
        bus.m = 5; bus.go = 1'b1; tick();
        bus.m = 9; tick();
        man_done = 4'b0001; tick();
        man_done = 4'b0000; tick();
        chk("t5_pe0_code", 64'(bus.start_signal[1:0]), 64'd1);
        chk("t5_pe0_row", 64'(bus.row_idx[0 +: ROW_W]), 64'd4);
        man_done = 4'b0010; tick();
        man_done = 4'b0000; tick();
        chk("t5_pe1_no_relatch", 64'(bus.start_signal[3:2]), 64'd0);
        chk("t5_rows_done", 64'(bus.rows_done), 64'd2);
        rst = 1'b1; bus.go = 1'b0; tick();
        chk("t5_rst_start", 64'(bus.start_signal), 64'd0);
        chk("t5_rst_row_idx", 64'(bus.row_idx[63:0]), 64'd0);
        chk("t5_rst_busy", 64'(bus.busy), 64'd0);
        chk("t5_rst_done", 64'(bus.done), 64'd0);
        chk("t5_rst_rows_done", 64'(bus.rows_done), 64'd0);
        rst = 1'b0; man_done = 4'b1111; tick(); man_done = 4'b0000;
        chk("t5_stale_done", 64'(bus.rows_done), 64'd0);
        resp_dly = 2;
        bus.m = 2; bus.go = 1'b1; tick(); bus.go = 1'b0;
        chk("t5_m2_start", 64'(bus.start_signal), 64'h05);
        wait_done(40, "t5_m2_done");
        chk("t5_m2_rows_done", 64'(bus.rows_done), 64'd2);
        tick();

`ifdef PE_DISPATCH_ABORT_EN
        resp_dly = 0; dut_done_cnt = 0;
        bus.m = 8; bus.go = 1'b1; tick(); bus.go = 1'b0;
        tick(); tick(); tick();
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        chk("t6_start_abort", 64'(bus.start_signal), 64'hFF);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_aborted", 64'(bus.aborted), 64'd1);
        chk("t6_rows_done", 64'(bus.rows_done), 64'd0);
        tick();
        chk("t6_start_after", 64'(bus.start_signal), 64'd0);
        repeat (3) tick();
        chk("t6_no_done", 64'(dut_done_cnt), 64'd0);
        chk("t6_aborted_sticky", 64'(bus.aborted), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
